pow_n_scheduler: RTL and testbench

POW_N_SCHEDULER -- requirements
Module: pow_n_scheduler

---
 rtl/pow_n_pkg.sv | 13 +
 rtl/pow_n_rr_arbiter.sv | 23 ++
 rtl/pow_n_scheduler.sv | 101 ++++++++++
 tb/tb_pow_n_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_n_pkg.sv
// Shared types and default sizing for the pow_n scheduler slice.
package pow_n_pkg;

  localparam int unsigned POW_N_W  = 18;
  localparam int unsigned POW_N_EW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } pow_n_state_e;

endpackage

// File: rtl/pow_n_rr_arbiter.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the
// requester that was not served last.
module pow_n_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant
);

  // Grant decode; nothing is granted while disabled.
  always_comb begin
    grant = '0;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/pow_n_scheduler.sv
// Computes n**exp mod 2^W for two requesters sharing one multiplier,
// one multiply per cycle, with round-robin selection between them.
module pow_n_scheduler
  import pow_n_pkg::*;
#(
  parameter int unsigned W  = POW_N_W,
  parameter int unsigned EW = POW_N_EW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*W-1:0]    req_n,
  input  logic [2*EW-1:0]   req_exp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              busy
);

  pow_n_state_e   state, state_nxt;
  logic [W-1:0]   acc;
  logic [W-1:0]   n_q;
  logic [EW-1:0]  count;
  logic           id_q;
  logic           last_q;

  logic [1:0]     grant;
  logic           arb_en;
  logic           accept;
  logic           sel;
  logic [W-1:0]   sel_n;
  logic [EW-1:0]  sel_exp;
  logic [W-1:0]   prod;

  // Grants are gated by reset so req_ready reads 00 while reset is held.
  assign arb_en = (state == IDLE) && reset_n;

  pow_n_rr_arbiter u_arb (
    .req    (req_valid),
    .last   (last_q),
    .enable (arb_en),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel       = grant[1];
  assign sel_n     = sel ? req_n[W +: W]     : req_n[0 +: W];
  assign sel_exp   = sel ? req_exp[EW +: EW] : req_exp[0 +: EW];

  // The single shared multiplier; truncation to W bits is the modulo.
  assign prod = acc * n_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (sel_exp <= EW'(1)) ? DONE : CALC;
      CALC: if (count == EW'(1)) state_nxt = DONE;
      DONE: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, then multiply once per CALC cycle.
  always_ff @(posedge clock) begin
    if (state == IDLE && accept) begin
      n_q   <= sel_n;
      count <= sel_exp - EW'(1);
      acc   <= (sel_exp == '0) ? W'(1) : sel_n;
    end else if (state == CALC) begin
      acc   <= prod;
      count <= count - EW'(1);
    end
  end

  // Owner of the current operation and the round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q   <= 1'b0;
      last_q <= 1'b1;
    end else begin
      if (state == IDLE && accept) id_q <= sel;
      if (state == DONE && rsp_ready) last_q <= id_q;
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_data  = rsp_valid ? acc : '0;
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pow_n_scheduler.sv
// Self-checking bench for pow_n_scheduler: transaction-level reference
// model compared every cycle, directed scenarios and a random phase.
module tb_pow_n_scheduler;

  localparam int unsigned W  = 18;
  localparam int unsigned EW = 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic [2*W-1:0]    req_n = '0;
  logic [2*EW-1:0]   req_exp = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;

  pow_n_scheduler #(.W(W), .EW(EW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .req_exp   (req_exp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: busy flag, cycles left until the result shows,
  // the result itself, its owner and the last-served requester.
  bit           m_busy = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_res = '0;
  bit           m_id = 1'b0;
  bit           m_last = 1'b1;

  bit prev_rv = 1'b0;
  int first_cyc = 0;
  int acc_cyc = 0;

  logic [W-1:0] q_data[$];
  bit           q_id[$];
  int           q_lat[$];
  int           q_acc[$];
  int           q_hs[$];

  function automatic logic [W-1:0] pw(input logic [W-1:0] n, input logic [EW-1:0] e);
    logic [W-1:0] r;
    r = W'(1);
    for (int unsigned k = 0; k < int'(e); k++) r = r * n;
    return r;
  endfunction

  function automatic logic [1:0] rr(input logic [1:0] v, input bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  // Per-cycle compare against the model, response logging, model advance.
  task automatic mon();
    logic [1:0] er;
    bit         erv;
    int         e;
    if (!reset_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id",    32'(rsp_id),    32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      m_busy = 1'b0; m_wait = 0; m_last = 1'b1; prev_rv = 1'b0;
    end else begin
      er  = m_busy ? 2'b00 : rr(req_valid, m_last);
      erv = m_busy && (m_wait == 0);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("busy",      32'(busy),      32'(m_busy));
      if (erv) begin
        chk("rsp_data", 32'(rsp_data), 32'(m_res));
        chk("rsp_id",   32'(rsp_id),   32'(m_id));
      end
      if ((req_valid & req_ready) != 2'b00) acc_cyc = cyc;
      if (rsp_valid && !prev_rv) first_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        q_data.push_back(rsp_data);
        q_id.push_back(rsp_id);
        q_lat.push_back(first_cyc - acc_cyc);
        q_acc.push_back(acc_cyc);
        q_hs.push_back(cyc);
      end
      prev_rv = rsp_valid;
      if (!m_busy) begin
        if (er != 2'b00) begin
          m_id   = er[1];
          e      = int'(req_exp[int'(m_id)*EW +: EW]);
          m_res  = pw(req_n[int'(m_id)*W +: W], EW'(e));
          m_wait = ((e == 0) ? 1 : e) - 1;
          m_busy = 1'b1;
        end
      end else if (m_wait != 0) begin
        m_wait--;
      end else if (rsp_ready) begin
        m_busy = 1'b0;
        m_last = m_id;
      end
    end
  endtask

  // One clock: compare at the falling edge, retire accepted requests
  // just after the rising edge.
  task automatic tick();
    logic [1:0] acc;
    @(negedge clock);
    mon();
    acc = req_valid & req_ready;
    @(posedge clock);
    cyc++;
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic raise(input int i, input logic [W-1:0] n, input logic [EW-1:0] e);
    req_n[i*W +: W]     = n;
    req_exp[i*EW +: EW] = e;
    req_valid[i]        = 1'b1;
  endtask

  task automatic wait_rsp(input int target);
    int b;
    b = 60;
    while (q_data.size() < target && b > 0) begin
      tick();
      b--;
    end
    if (q_data.size() < target) begin
      checks++;
      errors++;
      $display("FAIL wait_rsp timeout have=%0d want=%0d", q_data.size(), target);
    end
  endtask

  task automatic chk_rsp(input int k, input bit id, input logic [W-1:0] data, input int lat);
    if (q_data.size() > k) begin
      chk("lit_data", 32'(q_data[k]), 32'(data));
      chk("lit_id",   32'(q_id[k]),   32'(id));
      chk("lit_lat",  32'(q_lat[k]),  32'(lat));
    end else begin
      checks++;
      errors++;
      $display("FAIL lit_missing idx=%0d have=%0d", k, q_data.size());
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int base;
    int pre;
    int b;

    do_reset();

    // n=3, exp=5 from requester 0.
    base = q_data.size();
    raise(0, W'(3), EW'(5));
    wait_rsp(base + 1);
    chk_rsp(base, 1'b0, W'(243), 5);

    // Tie after reset, then a repeated tie.
    do_reset();
    base = q_data.size();
    raise(0, W'(2), EW'(3));
    raise(1, W'(5), EW'(2));
    wait_rsp(base + 2);
    raise(0, W'(2), EW'(3));
    raise(1, W'(5), EW'(2));
    wait_rsp(base + 4);
    chk_rsp(base,     1'b0, W'(8),  3);
    chk_rsp(base + 1, 1'b1, W'(25), 2);
    chk_rsp(base + 2, 1'b0, W'(8),  3);
    chk_rsp(base + 3, 1'b1, W'(25), 2);

    // Edge exponents and wrap.
    base = q_data.size();
    raise(0, W'(7), EW'(0));
    wait_rsp(base + 1);
    raise(1, W'(9), EW'(1));
    wait_rsp(base + 2);
    raise(0, W'('h3FFFF), EW'(2));
    wait_rsp(base + 3);
    chk_rsp(base,     1'b0, W'(1), 1);
    chk_rsp(base + 1, 1'b1, W'(9), 1);
    chk_rsp(base + 2, 1'b0, W'(1), 2);

    // Response stall with a competing request waiting.
    rsp_ready = 1'b0;
    base = q_data.size();
    raise(0, W'(3), EW'(2));
    b = 20;
    while (!rsp_valid && b > 0) begin
      tick();
      b--;
    end
    chk("stall_reach_done", 32'(rsp_valid), 32'd1);
    raise(1, W'(2), EW'(4));
    for (int s = 0; s < 4; s++) begin
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data",  32'(rsp_data),  32'd9);
      chk("stall_id",    32'(rsp_id),    32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_busy",  32'(busy),      32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    wait_rsp(base + 2);
    chk_rsp(base,     1'b0, W'(9),  2);
    chk_rsp(base + 1, 1'b1, W'(16), 4);
    if (q_data.size() > base + 1)
      chk("accept_after_hs", 32'(q_acc[base + 1]), 32'(q_hs[base] + 1));

    // Reset during CALC abandons the operation.
    pre = q_data.size();
    raise(0, W'(2), EW'(7));
    b = 10;
    while (req_valid[0] && b > 0) begin
      tick();
      b--;
    end
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_busy",  32'(busy),      32'd0);
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("no_rsp_after_reset", 32'(q_data.size()), 32'(pre));
    base = q_data.size();
    raise(0, W'(4), EW'(2));
    wait_rsp(base + 1);
    chk_rsp(base, 1'b0, W'(16), 2);

    // Random traffic, including withdrawn requests and rare resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) raise(i, W'($urandom), EW'($urandom_range(0, 7)));
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset_n   = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
